// File: rtl/cmp_flags_pipe_if.sv
// Valid/ready operation and result bundle for cmp_flags_pipe.
// The Out signal exists only when CMP_RESULT_EN is defined.
interface cmp_flags_pipe_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic [1:0]       Op;
  logic [3:0]       Cond;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       Flags;
  logic             CondTrue;
`ifdef CMP_RESULT_EN
  logic [WIDTH-1:0] Out;
`endif

  modport master (
    output in_valid, In1, In2, Op, Cond, out_ready,
    input  in_ready, out_valid, Flags, CondTrue
`ifdef CMP_RESULT_EN
    , input Out
`endif
  );

  modport slave (
    input  in_valid, In1, In2, Op, Cond, out_ready,
    output in_ready, out_valid, Flags, CondTrue
`ifdef CMP_RESULT_EN
    , output Out
`endif
  );
endinterface

// File: rtl/cmp_flags_pipe.sv
// Two-stage compare/flag unit: NZCV flag register plus registered condition evaluation.
// Optional feature macro CMP_RESULT_EN adds the registered Out result port.
module cmp_flags_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  cmp_flags_pipe_if.slave  bus
);

  localparam int MSB = WIDTH - 1;

  logic             s1_valid;
  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic [1:0]       s1_op;
  logic [3:0]       s1_cond;
  logic             s1_a_msb;
  logic             s1_b_msb;
  logic [WIDTH:0]   raw;
  logic             out_valid_q;
  logic             cond_true_q;
  logic [3:0]       flags_q;
  logic             n_new;
  logic             z_new;
  logic             c_raw;
  logic             v_arith;
  logic [3:0]       flags_new;
`ifdef CMP_RESULT_EN
  logic [WIDTH:0]   s1_res;
  logic [WIDTH-1:0] out_q;
`else
  logic             s1_n;
  logic             s1_z;
  logic             s1_c;
`endif

  assign s2_adv       = !out_valid_q || bus.out_ready;
  assign s1_adv       = s1_valid && s2_adv;
  assign bus.in_ready = !s1_valid || s2_adv;
  assign accept       = bus.in_valid && bus.in_ready;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, r;
    {n, z, c, v} = f;
    r = 1'b0;
    case (cond)
      4'd0:    r = z;
      4'd1:    r = !z;
      4'd2:    r = c;
      4'd3:    r = !c;
      4'd4:    r = n;
      4'd5:    r = !n;
      4'd6:    r = v;
      4'd7:    r = !v;
      4'd8:    r = !c && !z;
      4'd9:    r = c || z;
      4'd10:   r = (n == v);
      4'd11:   r = (n != v);
      4'd12:   r = !z && (n == v);
      4'd13:   r = z || (n != v);
      4'd14:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Zero-extended operands so bit WIDTH carries the borrow/carry for CMP/CMN.
  always_comb begin
    raw = '0;
    case (bus.Op)
      2'b00:   raw = {1'b0, bus.In1} - {1'b0, bus.In2};
      2'b01:   raw = {1'b0, bus.In1} + {1'b0, bus.In2};
      2'b10:   raw = {1'b0, bus.In1 & bus.In2};
      default: raw = {1'b0, bus.In1 ^ bus.In2};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_cond  <= '0;
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
`ifdef CMP_RESULT_EN
      s1_res   <= '0;
`else
      s1_n     <= 1'b0;
      s1_z     <= 1'b0;
      s1_c     <= 1'b0;
`endif
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (accept) begin
        s1_op    <= bus.Op;
        s1_cond  <= bus.Cond;
        s1_a_msb <= bus.In1[MSB];
        s1_b_msb <= bus.In2[MSB];
`ifdef CMP_RESULT_EN
        s1_res   <= raw;
`else
        s1_n     <= raw[MSB];
        s1_z     <= (raw[MSB:0] == '0);
        s1_c     <= raw[WIDTH];
`endif
      end
    end
  end

`ifdef CMP_RESULT_EN
  assign n_new = s1_res[MSB];
  assign z_new = (s1_res[MSB:0] == '0);
  assign c_raw = s1_res[WIDTH];
`else
  assign n_new = s1_n;
  assign z_new = s1_z;
  assign c_raw = s1_c;
`endif

  // Logical ops inherit C/V from the register, which already holds the previous op's flags.
  assign v_arith   = s1_op[0] ? ((s1_a_msb == s1_b_msb) && (n_new != s1_a_msb))
                              : ((s1_a_msb != s1_b_msb) && (n_new != s1_a_msb));
  assign flags_new = s1_op[1] ? {n_new, z_new, flags_q[1:0]}
                              : {n_new, z_new, c_raw, v_arith};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      flags_q     <= 4'b0000;
      cond_true_q <= 1'b0;
`ifdef CMP_RESULT_EN
      out_q       <= '0;
`endif
    end else begin
      if (s2_adv) out_valid_q <= s1_valid;
      if (s1_adv) begin
        flags_q     <= flags_new;
        cond_true_q <= cond_eval(s1_cond, flags_new);
`ifdef CMP_RESULT_EN
        out_q       <= s1_res[MSB:0];
`endif
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.Flags     = flags_q;
  assign bus.CondTrue  = cond_true_q;
`ifdef CMP_RESULT_EN
  assign bus.Out       = out_q;
`endif

endmodule

// File: tb/tb_cmp_flags_pipe.sv
// Scoreboard bench for cmp_flags_pipe: a reference model pushes expected NZCV/CondTrue/result
// at each accept, and each scenario task pops and compares as results emerge.
module tb_cmp_flags_pipe;
  localparam int W = 32;

  typedef struct packed {
    logic [3:0]   flags;
    logic         ct;
    logic [W-1:0] res;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  exp_t       sb[$];
  logic [3:0] model_flags = 4'b0000;

  cmp_flags_pipe_if #(.WIDTH(W)) bus ();
  cmp_flags_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic cond_model(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return !(c || z);
      4'd9:  return c || z;
      4'd10: return !(n ^ v);
      4'd11: return n ^ v;
      4'd12: return !z && !(n ^ v);
      4'd13: return z || (n ^ v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Signed overflow is derived from wide signed arithmetic, independent of the MSB rules.
  task automatic push_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [3:0] cond);
    logic [W-1:0] res;
    logic n, z, c, v;
    longint s;
    exp_t e;
    c = model_flags[1];
    v = model_flags[0];
    case (op)
      2'd0: begin
        res = a - b;
        c = (a < b);
        v = (($signed(a) < $signed(b)) != res[W-1]);
      end
      2'd1: begin
        {c, res} = {1'b0, a} + {1'b0, b};
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2'd2: res = a & b;
      default: res = a ^ b;
    endcase
    n = res[W-1];
    z = (res == '0);
    model_flags = {n, z, c, v};
    e.flags = model_flags;
    e.ct    = cond_model(cond, model_flags);
    e.res   = res;
    sb.push_back(e);
  endtask

  // Offer one op (call just after a falling edge); returns after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] cond);
    bus.in_valid = 1'b1;
    bus.Op = op;
    bus.In1 = a;
    bus.In2 = b;
    bus.Cond = cond;
    #1;
    for (int i = 0; i < 200 && !bus.in_ready; i++) begin
      @(negedge clk);
      #1;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: in_ready got %b required 1", bus.in_ready);
    end else begin
      push_model(op, a, b, cond);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.In1 = '0;
    bus.In2 = '0;
    bus.Op = 2'd0;
    bus.Cond = 4'd0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    checks++;
    if (bus.Flags !== 4'b0000) begin failures++; $display("[TB] FAIL reset_flags: got %b required 0000", bus.Flags); end
    checks++;
    if (bus.CondTrue !== 1'b0) begin failures++; $display("[TB] FAIL reset_cond_true: got %b required 0", bus.CondTrue); end
`ifdef CMP_RESULT_EN
    checks++;
    if (bus.Out !== '0) begin failures++; $display("[TB] FAIL reset_out: got %h required 0", bus.Out); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_out_valid: got %b required 0", bus.out_valid); end
  endtask

  task automatic test_basic();
    exp_t e;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.Op = 2'd0;
    bus.In1 = 32'd5;
    bus.In2 = 32'd5;
    bus.Cond = 4'd0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL basic_in_ready: got %b required 1", bus.in_ready); end
    push_model(2'd0, 32'd5, 32'd5, 4'd0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_latency_early: out_valid got %b required 0", bus.out_valid); end
    @(posedge clk);
    @(negedge clk);
    #2;
    checks++;
    if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_latency: out_valid got %b required 1", bus.out_valid); end
    checks++;
    if (bus.Flags !== 4'b0100) begin failures++; $display("[TB] FAIL basic_flags: got %b required 0100", bus.Flags); end
    checks++;
    if (bus.CondTrue !== 1'b1) begin failures++; $display("[TB] FAIL basic_cond_eq: got %b required 1", bus.CondTrue); end
    e = sb.pop_front();
    checks++;
    if (bus.Flags !== e.flags) begin failures++; $display("[TB] FAIL basic_model_flags: got %b required %b", bus.Flags, e.flags); end
    @(posedge clk);
    @(negedge clk);
    #2;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_drain: out_valid got %b required 0", bus.out_valid); end
  endtask

  task automatic test_flags();
    logic [3:0] want_f [4];
    logic       want_c [4];
    exp_t e;
    int got;
    want_f[0] = 4'b1010; want_c[0] = 1'b1;
    want_f[1] = 4'b1010; want_c[1] = 1'b1;
    want_f[2] = 4'b0001; want_c[2] = 1'b0;
    want_f[3] = 4'b0110; want_c[3] = 1'b1;
    got = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    fork
      begin
        send(2'd0, 32'd1, 32'd2, 4'd2);
        send(2'd0, 32'd1, 32'd2, 4'd11);
        send(2'd0, 32'h8000_0000, 32'd1, 4'd10);
        send(2'd1, 32'hFFFF_FFFF, 32'd1, 4'd0);
      end
      begin
        for (int i = 0; i < 60 && got < 4; i++) begin
          @(negedge clk);
          #2;
          if (bus.out_valid) begin
            checks++;
            if (bus.Flags !== want_f[got]) begin failures++; $display("[TB] FAIL flags_case%0d: got %b required %b", got, bus.Flags, want_f[got]); end
            checks++;
            if (bus.CondTrue !== want_c[got]) begin failures++; $display("[TB] FAIL cond_case%0d: got %b required %b", got, bus.CondTrue, want_c[got]); end
            if (sb.size() == 0) begin
              checks++; failures++;
              $display("[TB] FAIL flags_sb_empty: unexpected result %b", bus.Flags);
            end else begin
              e = sb.pop_front();
              checks++;
              if (bus.Flags !== e.flags) begin failures++; $display("[TB] FAIL flags_model%0d: got %b required %b", got, bus.Flags, e.flags); end
`ifdef CMP_RESULT_EN
              checks++;
              if (bus.Out !== e.res) begin failures++; $display("[TB] FAIL flags_out%0d: got %h required %h", got, bus.Out, e.res); end
`endif
            end
            got++;
          end
        end
        if (got < 4) begin checks++; failures++; $display("[TB] FAIL flags_timeout: got %0d results required 4", got); end
      end
    join
  endtask

  task automatic test_back_to_back();
    localparam int N = 10;
    exp_t e;
    int got, first_cyc, last_cyc;
    got = 0;
    first_cyc = 0;
    last_cyc = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    fork
      begin
        send(2'd0, 32'd1, 32'd2, 4'd0);
        send(2'd2, 32'hF0, 32'h0F, 4'd0);
        for (int k = 0; k < N - 2; k++) begin
          logic [W-1:0] b;
          logic [W-1:0] a;
          b = $urandom();
          a = ($urandom_range(0, 3) == 0) ? b : $urandom();
          send(2'($urandom_range(0, 3)), a, b, 4'($urandom_range(0, 15)));
        end
      end
      begin
        for (int i = 0; i < 100 && got < N; i++) begin
          @(negedge clk);
          #2;
          if (bus.out_valid) begin
            if (got == 0) first_cyc = cyc;
            last_cyc = cyc;
            if (got == 1) begin
              checks++;
              if (bus.Flags !== 4'b0110) begin failures++; $display("[TB] FAIL b2b_tst_inherit: got %b required 0110", bus.Flags); end
            end
            if (sb.size() == 0) begin
              checks++; failures++;
              $display("[TB] FAIL b2b_sb_empty: unexpected result %b", bus.Flags);
            end else begin
              e = sb.pop_front();
              checks++;
              if (bus.Flags !== e.flags) begin failures++; $display("[TB] FAIL b2b_flags%0d: got %b required %b", got, bus.Flags, e.flags); end
              checks++;
              if (bus.CondTrue !== e.ct) begin failures++; $display("[TB] FAIL b2b_cond%0d: got %b required %b", got, bus.CondTrue, e.ct); end
`ifdef CMP_RESULT_EN
              checks++;
              if (bus.Out !== e.res) begin failures++; $display("[TB] FAIL b2b_out%0d: got %h required %h", got, bus.Out, e.res); end
`endif
            end
            got++;
          end
        end
        checks++;
        if (got != N || last_cyc - first_cyc != N - 1) begin
          failures++;
          $display("[TB] FAIL b2b_throughput: got %0d results over %0d cycles required %0d over %0d", got, last_cyc - first_cyc + 1, N, N);
        end
      end
    join
  endtask

  task automatic test_backpressure();
    exp_t e;
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(2'd0, 32'd1, 32'd2, 4'd2);
    send(2'd1, 32'd7, 32'd9, 4'd1);
    bus.in_valid = 1'b1;
    bus.Op = 2'd3;
    bus.In1 = 32'h55;
    bus.In2 = 32'h55;
    bus.Cond = 4'd0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_third_blocked: in_ready got %b required 0", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready_hold%0d: got %b required 0", i, bus.in_ready); end
      checks++;
      if (bus.Flags !== 4'b1010 || bus.CondTrue !== 1'b1) begin
        failures++;
        $display("[TB] FAIL bp_flags_hold%0d: got %b/%b required 1010/1", i, bus.Flags, bus.CondTrue);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_ready: got %b required 1", bus.in_ready); end
    push_model(2'd3, 32'h55, 32'h55, 4'd0);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_no_bubble%0d: out_valid got %b required 1", i, bus.out_valid); end
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL bp_sb_empty: unexpected result %b", bus.Flags);
      end else begin
        e = sb.pop_front();
        checks++;
        if (bus.Flags !== e.flags) begin failures++; $display("[TB] FAIL bp_flags%0d: got %b required %b", i, bus.Flags, e.flags); end
        checks++;
        if (bus.CondTrue !== e.ct) begin failures++; $display("[TB] FAIL bp_cond%0d: got %b required %b", i, bus.CondTrue, e.ct); end
`ifdef CMP_RESULT_EN
        checks++;
        if (bus.Out !== e.res) begin failures++; $display("[TB] FAIL bp_out%0d: got %h required %h", i, bus.Out, e.res); end
`endif
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #2;
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_drained: out_valid got %b required 0", bus.out_valid); end
  endtask

  task automatic test_random_stall();
    localparam int N = 12;
    exp_t e;
    int got;
    logic stalled;
    logic [3:0] held_flags;
    logic held_ct;
    got = 0;
    stalled = 1'b0;
    held_flags = 4'b0000;
    held_ct = 1'b0;
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < N; k++)
          send(2'($urandom_range(0, 3)), $urandom(), $urandom_range(0, 3) == 0 ? 32'h0 : $urandom(),
               4'($urandom_range(0, 15)));
      end
      begin
        for (int i = 0; i < 600 && got < N; i++) begin
          @(negedge clk);
          bus.out_ready = ($urandom_range(0, 2) != 0);
          #2;
          if (stalled) begin
            checks++;
            if (bus.Flags !== held_flags || bus.CondTrue !== held_ct) begin
              failures++;
              $display("[TB] FAIL stall_hold: got %b/%b required %b/%b", bus.Flags, bus.CondTrue, held_flags, held_ct);
            end
          end
          stalled = bus.out_valid && !bus.out_ready;
          held_flags = bus.Flags;
          held_ct = bus.CondTrue;
          if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
              checks++; failures++;
              $display("[TB] FAIL stall_sb_empty: unexpected result %b", bus.Flags);
            end else begin
              e = sb.pop_front();
              checks++;
              if (bus.Flags !== e.flags || bus.CondTrue !== e.ct) begin
                failures++;
                $display("[TB] FAIL stall_result%0d: got %b/%b required %b/%b", got, bus.Flags, bus.CondTrue, e.flags, e.ct);
              end
`ifdef CMP_RESULT_EN
              checks++;
              if (bus.Out !== e.res) begin failures++; $display("[TB] FAIL stall_out%0d: got %h required %h", got, bus.Out, e.res); end
`endif
            end
            got++;
          end
        end
        if (got < N) begin checks++; failures++; $display("[TB] FAIL stall_timeout: got %0d results required %0d", got, N); end
      end
    join
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    int got;
    got = 0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(2'd0, 32'd1, 32'd2, 4'd2);
    send(2'd0, 32'd4, 32'd4, 4'd0);
    #3;
    checks++;
    if (bus.Flags !== 4'b1010) begin failures++; $display("[TB] FAIL midrst_pre_flags: got %b required 1010", bus.Flags); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_out_valid: got %b required 0", bus.out_valid); end
    checks++;
    if (bus.Flags !== 4'b0000) begin failures++; $display("[TB] FAIL midrst_flags: got %b required 0000", bus.Flags); end
    checks++;
    if (bus.CondTrue !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_ct_ready: got %b/%b required 0/1", bus.CondTrue, bus.in_ready);
    end
    sb.delete();
    model_flags = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    fork
      send(2'd0, 32'd3, 32'd2, 4'd3);
      begin
        for (int i = 0; i < 40 && got < 1; i++) begin
          @(negedge clk);
          #2;
          if (bus.out_valid) begin
            checks++;
            if (bus.Flags !== 4'b0000 || bus.CondTrue !== 1'b1) begin
              failures++;
              $display("[TB] FAIL midrst_after: got %b/%b required 0000/1", bus.Flags, bus.CondTrue);
            end
            if (sb.size() != 0) begin
              e = sb.pop_front();
              checks++;
              if (bus.Flags !== e.flags) begin failures++; $display("[TB] FAIL midrst_model: got %b required %b", bus.Flags, e.flags); end
            end
            got++;
          end
        end
        if (got < 1) begin checks++; failures++; $display("[TB] FAIL midrst_timeout: got %0d results required 1", got); end
      end
    join
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    checks++;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
